seq_booth_mul: RTL and testbench
================================

Name: seq_booth_mul

Overview:
- Iterative radix-2 Booth multiplier for the CPU execute stage, parametrised in operand width.
- Accepts one operand pair through a valid/ready handshake and retires one Booth step per clock.
- Returns the full double-width product through a second valid/ready handshake.
- Adds per-operation signed/unsigned mode, backpressure and back-to-back issue, which the combinational multiplier lacks.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH; minimum 4.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair.
- in_signed  input  1  1 = treat operands as two's complement; 0 = unsigned.
- in_a  input  WIDTH  multiplier (the operand scanned by Booth recoding).
- in_b  input  WIDTH  multiplicand.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer takes the product.
- out_p  output  2*WIDTH  product a*b.
- busy  output  1  high while iterating (state BUSY).

Interface note: one clock, clk; reset is asynchronous and active-low, rst_n.

Behaviour:
- **Reset.** rst_n low asynchronously forces:
  - state IDLE;
  - out_valid=0, out_p=0, busy=0, counter=0, all datapath registers 0;
  - in_ready becomes 1 once reset is released.
- **Reset mid-operation** discards the operation; no out_valid is produced for it.
- **States:**
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, busy=1.
  - DONE: out_valid=1, out_p held stable.
- **Accept.** A pair is accepted on a rising edge where in_valid && in_ready. At acceptance:
  - operands are extended to WIDTH+1 bits (sign-extended if in_signed, zero-extended otherwise);
  - accumulator high half is cleared, low half is loaded with the extended multiplier, Booth bit E=0;
  - counter=0; state goes to BUSY.
- **Each BUSY edge** performs one step on bit pair {acc[0], E}:
  - 10: high half minus multiplicand.
  - 01: high half plus multiplicand.
  - 00 or 11: no add.
  - Then an arithmetic right shift of {high, low, E} by one; counter increments.
  - High half is WIDTH+2 bits wide so that -(-2^(WIDTH-1)) cannot overflow.
- **Iteration count.** Exactly WIDTH+1 steps. After the step with counter==WIDTH:
  - out_p is registered with the low 2*WIDTH bits of the (2*WIDTH+2)-bit result;
  - state goes to DONE.
- **Latency.** out_valid rises on the (WIDTH+1)th edge after the accepting edge (33 cycles at WIDTH=32), independent of operand values. No early termination.
- **DONE with out_ready=0.** out_valid and out_p hold indefinitely; in_ready=0.
- **Leaving DONE.** in_ready = (state==IDLE) || (state==DONE && out_ready).
  - On an edge with out_ready=1 and no new accept: state goes to IDLE, out_valid=0. out_p keeps its last value (don't-care to consumers).
  - On the same edge, out_ready=1 and in_valid=1: the product is retired and the new pair is accepted simultaneously; state goes directly to BUSY, out_valid=0. Issue interval is WIDTH+2 cycles.
- **Operand stability.** in_a, in_b and in_signed are sampled only at acceptance; later changes have no effect.
- **Ignored inputs.** in_valid while BUSY is ignored and is not queued.
- **Arithmetic.**
  - Signed mode: out_p = a*b exactly, two's complement.
  - Unsigned mode: out_p = a*b exactly, with no overflow.
  - No flags are produced.

Decomposition:
- Shared package mul_pkg holds:
  - state enum mul_state_t {IDLE, BUSY, DONE};
  - Booth encoding constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
- One combinational sub-module, booth_step. Parametrised by WIDTH, it takes {high, low, E} and the multiplicand, and returns the next {high, low, E}.
- seq_booth_mul holds the FSM, counter, handshake and registers.

Test Plan:
- Signed 7 * -3, WIDTH=32 → out_p=0xFFFFFFFF_FFFFFFEB. out_valid rises exactly 33 edges after acceptance; busy is high for 33 cycles.
- Mode corners with a=b=0xFFFFFFFF:
  - unsigned → 0xFFFFFFFE_00000001;
  - signed → 0x00000000_00000001.
- Signed 0x80000000 * 0x80000000 → 0x40000000_00000000. Signed 0x80000000 * 1 → 0xFFFFFFFF_80000000.
- Backpressure:
  - hold out_ready=0 for 10 cycles in DONE → out_p stable, in_ready=0, and an in_valid pulse is not accepted;
  - out_ready=1 with in_valid=1 on the same edge → retire plus accept, next product 5*6=30 after another 33 edges.
- Reset: assert rst_n=0 at counter=15 mid-operation → out_valid, busy and out_p go to 0 immediately. After release, in_ready=1 and a fresh 2*3 gives 6 with no stale result.
- Random sweep at WIDTH=8 and WIDTH=32 (≥10k ops, random mode and out_ready stalls) → every out_p matches the reference model; the count of products equals the count of accepts.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// Booth recoding pairs {acc[0], E} that trigger an add or a subtract.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_booth_mul_if.sv
// Operand-in / product-out handshake bundle of the sequential Booth multiplier.
// The master issues operand pairs and drains products; the slave is the multiplier.
interface seq_booth_mul_if #(
  parameter int WIDTH = 32
);

  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the high half, then an arithmetic right shift of {high, low, E}.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] hi,
  input  logic [WIDTH:0]   lo,
  input  logic             e,
  input  logic [WIDTH:0]   mcand,
  output logic [WIDTH+1:0] hi_n,
  output logic [WIDTH:0]   lo_n,
  output logic             e_n
);

  logic [WIDTH+1:0] mc_x;
  logic [WIDTH+1:0] sum;

  assign mc_x = {mcand[WIDTH], mcand};

  always_comb begin
    sum = hi;
    case ({lo[0], e})
      BOOTH_ADD: sum = hi + mc_x;
      BOOTH_SUB: sum = hi - mc_x;
      default:   sum = hi;
    endcase
  end

  assign hi_n = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign lo_n = {sum[0], lo[WIDTH:1]};
  assign e_n  = lo[0];

endmodule

// File: rtl/seq_booth_mul.sv
// Iterative radix-2 Booth multiplier: one step per clock, WIDTH+1 steps per operation,
// double-width product held in DONE until the consumer takes it.
module seq_booth_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_booth_mul_if.slave     bus,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  mul_state_t       state;
  mul_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] hi;
  logic [WIDTH+1:0] hi_n;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   lo_n;
  logic [WIDTH:0]   mcand;
  logic             e;
  logic             e_n;
  logic             accept;
  logic             last;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Retiring and accepting on the same edge skips IDLE entirely.
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) state_nx = bus.in_valid ? BUSY : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  booth_step #(.WIDTH(WIDTH)) u_step (
    .hi    (hi),
    .lo    (lo),
    .e     (e),
    .mcand (mcand),
    .hi_n  (hi_n),
    .lo_n  (lo_n),
    .e_n   (e_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      e         <= 1'b0;
      mcand     <= '0;
      cnt       <= '0;
      bus.out_p <= '0;
    end else if (accept) begin
      hi    <= '0;
      lo    <= {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
      e     <= 1'b0;
      mcand <= {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};
      cnt   <= '0;
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      e   <= e_n;
      cnt <= cnt + CNT_W'(1);
      if (last) bus.out_p <= {hi_n[WIDTH-2:0], lo_n};
    end
  end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Self-checking bench: directed corner/handshake/reset scenarios at WIDTH=32 and
// concurrent random sweeps at WIDTH=8 and WIDTH=32 scored against plain multiplication.
module tb_seq_booth_mul;

  logic clk;
  logic rst_n;
  logic busy32;
  logic busy8;
  int   n_cmp;
  int   n_err;

  seq_booth_mul_if #(.WIDTH(32)) b32 ();
  seq_booth_mul_if #(.WIDTH(8))  b8 ();

  seq_booth_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .busy(busy32));
  seq_booth_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8),  .busy(busy8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one pair into the idle 32-bit unit and wait (bounded) for its product.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat, output int bcnt);
    @(negedge clk);
    b32.in_valid  = 1'b1;
    b32.in_signed = s;
    b32.in_a      = a;
    b32.in_b      = b;
    @(posedge clk);
    #1;
    b32.in_valid  = 1'b0;
    b32.in_a      = $urandom;
    b32.in_b      = $urandom;
    b32.in_signed = ~s;
    lat  = 0;
    bcnt = 0;
    while (!b32.out_valid && lat < 200) begin
      if (busy32) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    p = b32.out_p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.in_signed  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({b32.in_ready, b32.out_valid, busy32} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100", {b32.in_ready, b32.out_valid, busy32});
    end
    n_cmp++;
    if (b32.out_p !== 64'h0) begin
      n_err++; $display("FAIL reset_p32: got %h want 0", b32.out_p);
    end
    n_cmp++;
    if ({b8.in_ready, b8.out_valid, busy8, b8.out_p} !== {3'b100, 16'h0}) begin
      n_err++; $display("FAIL reset_w8: got %b/%h want 100/0", {b8.in_ready, b8.out_valid, busy8}, b8.out_p);
    end
  endtask

  task automatic test_basic();
    logic [63:0] p;
    int lat, bc;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, p, lat, bc);
    n_cmp++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_err++; $display("FAIL basic_p: got %h want ffffffffffffffeb", p);
    end
    n_cmp++;
    if (lat !== 33) begin
      n_err++; $display("FAIL basic_latency: got %0d want 33", lat);
    end
    n_cmp++;
    if (bc !== 33) begin
      n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", bc);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({b32.in_ready, b32.out_valid, busy32} !== 3'b100) begin
      n_err++; $display("FAIL basic_retire: got %b want 100", {b32.in_ready, b32.out_valid, busy32});
    end
  endtask

  task automatic test_corners();
    logic [31:0] ca [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] cb [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    logic        cs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] ce [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                            64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    logic [63:0] p;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(cs[i], ca[i], cb[i], p, lat, bc);
      n_cmp++;
      if (p !== ce[i]) begin
        n_err++; $display("FAIL corner_%0d: got %h want %h", i, p, ce[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    int lat, bc;
    @(negedge clk);
    b32.out_ready = 1'b0;
    run_op(1'b0, 32'h1234, 32'h10, p, lat, bc);
    n_cmp++;
    if (p !== 64'h12340) begin
      n_err++; $display("FAIL bp_p: got %h want 12340", p);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b32.in_valid = (i == 4);
      b32.in_a = 32'd9;
      b32.in_b = 32'd9;
      #1;
      n_cmp++;
      if ({b32.in_ready, b32.out_valid, b32.out_p} !== {2'b01, 64'h12340}) begin
        n_err++; $display("FAIL bp_hold_%0d: got rdy=%b vld=%b p=%h want rdy=0 vld=1 p=12340",
                          i, b32.in_ready, b32.out_valid, b32.out_p);
      end
    end
    @(negedge clk);
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    b32.in_signed = 1'b0;
    b32.in_a      = 32'd5;
    b32.in_b      = 32'd6;
    #1;
    n_cmp++;
    if (b32.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_on_retire: got %b want 1", b32.in_ready);
    end
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    b32.in_a     = 32'd100;
    n_cmp++;
    if ({b32.out_valid, busy32} !== 2'b01) begin
      n_err++; $display("FAIL bp_retire_accept: got vld/busy %b want 01", {b32.out_valid, busy32});
    end
    lat = 0;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 33 || b32.out_p !== 64'd30) begin
      n_err++; $display("FAIL bp_next: got lat=%0d p=%h want lat=33 p=1e", lat, b32.out_p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat, bc;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_signed = 1'b1; b32.in_a = 32'h12345; b32.in_b = 32'h777;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b32.out_valid, busy32, b32.out_p} !== {2'b00, 64'h0}) begin
      n_err++; $display("FAIL rst_mid: got vld=%b busy=%b p=%h want 0/0/0", b32.out_valid, busy32, b32.out_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({b32.in_ready, b32.out_valid} !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_release: got rdy/vld %b want 10", {b32.in_ready, b32.out_valid});
    end
    run_op(1'b0, 32'd2, 32'd3, p, lat, bc);
    n_cmp++;
    if (p !== 64'd6 || lat !== 33) begin
      n_err++; $display("FAIL rst_mid_fresh: got p=%h lat=%0d want p=6 lat=33", p, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random32(input int nops);
    logic [63:0] q [$];
    logic [63:0] exp;
    int acc = 0, ret = 0, guard = 0;
    while ((acc < nops || q.size() != 0) && guard < 60000) begin
      @(negedge clk);
      if (acc < nops) begin
        b32.in_valid  = ($urandom_range(0, 3) != 0);
        b32.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
      end
      b32.in_signed = 1'($urandom_range(0, 1));
      b32.in_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b32.in_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      #1;
      if (b32.out_valid && b32.out_ready) begin
        n_cmp++;
        ret++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd32_extra: got product %h with none outstanding", b32.out_p);
        end else begin
          exp = q.pop_front();
          if (b32.out_p !== exp) begin
            n_err++; $display("FAIL rnd32_p: got %h want %h", b32.out_p, exp);
          end
        end
      end
      if (b32.in_valid && b32.in_ready) begin
        acc++;
        if (b32.in_signed) q.push_back(64'(longint'($signed(b32.in_a)) * longint'($signed(b32.in_b))));
        else               q.push_back({32'h0, b32.in_a} * {32'h0, b32.in_b});
      end
      guard++;
    end
    n_cmp++;
    if (acc !== nops || ret !== acc) begin
      n_err++; $display("FAIL rnd32_count: got accepts=%0d products=%0d want %0d each", acc, ret, nops);
    end
  endtask

  task automatic test_random8(input int nops);
    logic [15:0] q [$];
    logic [15:0] exp;
    int acc = 0, ret = 0, guard = 0;
    while ((acc < nops || q.size() != 0) && guard < 60000) begin
      @(negedge clk);
      if (acc < nops) begin
        b8.in_valid  = ($urandom_range(0, 3) != 0);
        b8.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
      end
      b8.in_signed = 1'($urandom_range(0, 1));
      b8.in_a = 8'($urandom);
      b8.in_b = 8'($urandom);
      #1;
      if (b8.out_valid && b8.out_ready) begin
        n_cmp++;
        ret++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd8_extra: got product %h with none outstanding", b8.out_p);
        end else begin
          exp = q.pop_front();
          if (b8.out_p !== exp) begin
            n_err++; $display("FAIL rnd8_p: got %h want %h", b8.out_p, exp);
          end
        end
      end
      if (b8.in_valid && b8.in_ready) begin
        acc++;
        if (b8.in_signed) q.push_back(16'(int'($signed(b8.in_a)) * int'($signed(b8.in_b))));
        else              q.push_back(16'(int'(b8.in_a) * int'(b8.in_b)));
      end
      guard++;
    end
    n_cmp++;
    if (acc !== nops || ret !== acc) begin
      n_err++; $display("FAIL rnd8_count: got accepts=%0d products=%0d want %0d each", acc, ret, nops);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    fork
      test_random8(2500);
      test_random32(800);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
